mdu_iterative: RTL and testbench
================================

MDU_ITERATIVE -- requirements
Module: mdu_iterative

Interface
REQ-001 The block SHALL have parameter REG_SIZE, default 32, giving the operand, HI and LO width.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_start, input, 1 bit: single-cycle request to launch the operation in i_op.
REQ-005 The block SHALL have port i_op, input, 3 bits: operation code. 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU, 4 = MTHI, 5 = MTLO, 6 and 7 = no-op.
REQ-006 The block SHALL have port i_A, input, REG_SIZE bits: multiplicand, dividend, or MTHI/MTLO source (rs).
REQ-007 The block SHALL have port i_B, input, REG_SIZE bits: multiplier or divisor (rt).
REQ-008 The block SHALL have port o_busy, output, 1 bit: an iterative operation is in progress; the hazard unit uses it to stall MFHI/MFLO/MULT/DIV.
REQ-009 The block SHALL have port o_done, output, 1 bit: one-cycle pulse when HI/LO receive an iterative result.
REQ-010 The block SHALL have ports o_hi and o_lo, outputs, REG_SIZE bits each: architectural HI and LO registers, read by MFHI/MFLO.

Function
REQ-011 The FSM SHALL have three states:
- IDLE: o_busy = 0.
- RUN: o_busy = 1; holds a 6-bit iteration counter.
- FIX: o_busy = 1.
REQ-012 In IDLE, i_start with i_op in 0..3 SHALL latch |i_A| and |i_B| (raw values for MULTU/DIVU), the op and the result signs, clear the counter, and move to RUN.
REQ-013 In RUN, each cycle SHALL perform one shift-add multiply step or one restoring-divide step, and increment the counter. After 32 steps the FSM SHALL move to FIX.
REQ-014 In FIX, the FSM SHALL apply sign correction and write HI/LO, pulse o_done for that cycle, and return to IDLE.
REQ-015 Latency SHALL be fixed: start sampled at edge k; o_busy = 1 after edges k through k+32; HI/LO updated and o_done = 1 after edge k+33. Result readable in the cycle after o_done.
REQ-016 Multiply results SHALL be:
- MULT: {HI,LO} = signed 64-bit product.
- MULTU: {HI,LO} = unsigned 64-bit product.
REQ-017 DIV SHALL produce LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign.
REQ-018 DIVU SHALL produce the unsigned quotient and remainder.
REQ-019 On divide by zero (DIV or DIVU), the block SHALL write HI = i_A as latched and LO = 32'hFFFFFFFF, with unchanged latency.
REQ-020 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO = 32'h80000000, HI = 0.
REQ-021 MTHI/MTLO with i_start in IDLE SHALL write i_A into HI/LO on that edge. These ops SHALL NOT assert o_busy or o_done.
REQ-022 i_start SHALL be ignored while o_busy = 1, for every op. HI/LO SHALL stay unchanged until FIX.
REQ-023 Ops 6 and 7 SHALL have no effect.
REQ-024 o_hi and o_lo SHALL be registers that change only in FIX, on an MTHI/MTLO write, or on reset.

Reset
REQ-025 When i_reset = 1 at a rising edge, the block SHALL go to IDLE with o_busy = 0, o_done = 0, o_hi = 0, o_lo = 0, and counter and datapath registers cleared.
REQ-026 Reset in RUN or FIX SHALL abort the operation, with no o_done pulse and no HI/LO write. Reset SHALL take priority over i_start in the same cycle.

Verification
REQ-027 MULT with i_A = 32'hFFFFFFFD (-3), i_B = 5 -> o_done after 34 edges; HI = 32'hFFFFFFFF, LO = 32'hFFFFFFF1.
REQ-028 MULTU with i_A = i_B = 32'hFFFFFFFF -> HI = 32'hFFFFFFFE, LO = 32'h00000001.
REQ-029 DIV with i_A = -7, i_B = 2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF. DIVU with i_A = 7, i_B = 0 -> HI = 7, LO = 32'hFFFFFFFF.
REQ-030 MULT 3 x 4 started, then i_start MTLO 9 issued during RUN, then reset on the 10th RUN cycle -> MTLO ignored; after reset o_busy = 0, HI = LO = 0, and no o_done pulse.
REQ-031 MTHI 32'h12345678 in IDLE -> o_hi = 32'h12345678 the next cycle, and o_busy never asserts. A DIV started in the same cycle o_done pulses -> accepted, and its result appears 34 edges later.

Source files
------------

// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative multiply/divide unit with architectural HI/LO registers
module mdu_iterative #(
  parameter int REG_SIZE = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [2:0]          i_op,
  input  logic [REG_SIZE-1:0] i_A,
  input  logic [REG_SIZE-1:0] i_B,
  output logic                o_busy,
  output logic                o_done,
  output logic [REG_SIZE-1:0] o_hi,
  output logic [REG_SIZE-1:0] o_lo
);
  localparam int W = REG_SIZE;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;
  logic [5:0] cnt;
  logic is_div, neg_q, neg_r, sgn, ge;
  logic [W-1:0] acc_hi, acc_lo, m, abs_a, abs_b, dif, q, r;
  logic [W:0] add, sh;
  logic [2*W-1:0] prod;
  assign o_busy = state != IDLE;
  assign sgn = !i_op[0];
  assign abs_a = (sgn && i_A[W-1]) ? -i_A : i_A;
  assign abs_b = (sgn && i_B[W-1]) ? -i_B : i_B;
  // Multiply keeps the multiplier in acc_lo and shifts the partial product in from acc_hi;
  // divide shifts the dividend out of acc_lo into the remainder while quotient bits fill acc_lo.
  always_comb begin
    add = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    sh = {acc_hi, acc_lo[W-1]};
    ge = sh >= {1'b0, m};
    dif = W'(sh - {1'b0, m});
    prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    q = neg_q ? -acc_lo : acc_lo;
    r = neg_r ? -acc_hi : acc_hi;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      m <= '0;
      o_done <= 1'b0;
      o_hi <= '0;
      o_lo <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          if (!i_op[2]) begin
            is_div <= i_op[1];
            neg_q <= sgn & (i_A[W-1] ^ i_B[W-1]);
            neg_r <= sgn & i_A[W-1];
            acc_hi <= '0;
            acc_lo <= i_op[1] ? abs_a : abs_b;
            m <= i_op[1] ? abs_b : abs_a;
            cnt <= '0;
            state <= RUN;
          end else if (i_op == 3'd4) o_hi <= i_A;
          else if (i_op == 3'd5) o_lo <= i_A;
        end
        RUN: begin
          if (is_div) begin
            acc_hi <= ge ? dif : sh[W-1:0];
            acc_lo <= {acc_lo[W-2:0], ge};
          end else {acc_hi, acc_lo} <= {add, acc_lo[W-1:1]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'(W - 1)) state <= FIX;
        end
        FIX: begin
          // A zero divisor leaves the dividend as remainder; only the quotient is forced.
          o_hi <= is_div ? r : prod[2*W-1:W];
          o_lo <= is_div ? ((m == '0) ? '1 : q) : prod[W-1:0];
          o_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: randomized self-checking bench against an arithmetic HI/LO model
module tb_mdu_iterative;
  logic i_clk = 1'b0, i_reset = 1'b0, i_start = 1'b0;
  logic [2:0] i_op = 3'd0;
  logic [31:0] i_A = '0, i_B = '0;
  logic o_busy, o_done;
  logic [31:0] o_hi, o_lo;
  int total = 0, bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mdu_iterative #(.REG_SIZE(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_A(i_A), .i_B(i_B), .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    logic [63:0] p;
    int sa, sb;
    case (op)
      3'd0: begin x = $signed(a); y = $signed(b); p = x * y; {m_hi, m_lo} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      3'd2, 3'd3: begin
        if (b == 0) begin m_hi = a; m_lo = '1; end
        else if (op == 3'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin m_hi = 0; m_lo = a; end
        else if (op == 3'd2) begin sa = a; sb = b; m_lo = sa / sb; m_hi = sa % sb; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_iter(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] oh, ol;
    int lat;
    oh = m_hi; ol = m_lo;
    model(op, a, b);
    i_start = 1'b1; i_op = op; i_A = a; i_B = b;
    @(negedge i_clk);
    i_start = 1'b0; i_A = $urandom; i_B = $urandom;
    total++;
    if (o_busy !== 1'b1 || o_hi !== oh || o_lo !== ol) begin
      bad++;
      $display("FAIL %s early: busy=%b hi=%h lo=%h, required busy=1 hi=%h lo=%h", name, o_busy, o_hi, o_lo, oh, ol);
    end
    lat = 1;
    while (o_done !== 1'b1 && lat < 100) begin
      @(negedge i_clk);
      lat++;
    end
    total++;
    if (lat != 34 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s latency: edges=%0d busy=%b, required edges=34 busy=0", name, lat, o_busy);
    end
    total++;
    if (o_hi !== m_hi || o_lo !== m_lo) begin
      bad++;
      $display("FAIL %s result: hi=%h lo=%h, required hi=%h lo=%h (A=%h B=%h)", name, o_hi, o_lo, m_hi, m_lo, a, b);
    end
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input string name);
    model(op, a, 32'd0);
    i_start = 1'b1; i_op = op; i_A = a; i_B = $urandom;
    @(negedge i_clk);
    i_start = 1'b0;
    total++;
    if (o_hi !== m_hi || o_lo !== m_lo || o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL %s: hi=%h lo=%h busy=%b done=%b, required hi=%h lo=%h busy=0 done=0", name, o_hi, o_lo, o_busy, o_done, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_hi !== 32'd0 || o_lo !== 32'd0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required all zero", o_busy, o_done, o_hi, o_lo);
    end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_vectors();
    run_iter(3'd0, 32'hFFFFFFFD, 32'd5, "mult_neg3x5");
    run_iter(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    run_iter(3'd2, 32'hFFFFFFF9, 32'd2, "div_neg7by2");
    run_iter(3'd3, 32'd7, 32'd0, "divu_by0");
    run_iter(3'd2, 32'hFFFFFFF9, 32'd0, "div_neg_by0");
    run_iter(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
    run_iter(3'd2, 32'd7, 32'hFFFFFFFE, "div_7byneg2");
    run_iter(3'd0, 32'h80000000, 32'h80000000, "mult_minmin");
  endtask

  task automatic test_mt();
    run_mt(3'd4, 32'h12345678, "mthi");
    run_mt(3'd5, 32'hCAFEF00D, "mtlo");
    run_mt(3'd6, 32'h11111111, "noop6");
    run_mt(3'd7, 32'h22222222, "noop7");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) a = -a;
      if (op < 3'd4) run_iter(op, a, b, "random");
      else run_mt(op, a, "random_mt");
    end
  endtask

  task automatic test_abort();
    logic [31:0] ol;
    bit seen;
    ol = m_lo;
    i_start = 1'b1; i_op = 3'd0; i_A = 32'd3; i_B = 32'd4;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    i_start = 1'b1; i_op = 3'd5; i_A = 32'd9;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (7) @(negedge i_clk);
    total++;
    if (o_lo !== ol || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_mtlo_ignored: lo=%h busy=%b, required lo=%h busy=1", o_lo, o_busy, ol);
    end
    i_reset = 1'b1; i_start = 1'b1; i_op = 3'd4; i_A = 32'hDEADBEEF;
    @(negedge i_clk);
    i_reset = 1'b0; i_start = 1'b0;
    m_hi = 0; m_lo = 0;
    total++;
    if (o_busy !== 1'b0 || o_hi !== 32'd0 || o_lo !== 32'd0) begin
      bad++;
      $display("FAIL abort_reset: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", o_busy, o_hi, o_lo);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (o_done || o_busy || o_hi != 0 || o_lo != 0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_quiet: activity=1 after reset, required none (hi=%h lo=%h)", o_hi, o_lo);
    end
  endtask

  task automatic test_back_to_back();
    bit busy_seen;
    run_mt(3'd4, 32'h12345678, "b2b_mthi");
    busy_seen = o_busy;
    @(negedge i_clk);
    busy_seen |= o_busy;
    total++;
    if (busy_seen || o_hi !== 32'h12345678) begin
      bad++;
      $display("FAIL b2b_mthi_nobusy: busy_seen=%b hi=%h, required 0 and 12345678", busy_seen, o_hi);
    end
    run_iter(3'd2, 32'd100, 32'd7, "b2b_div1");
    run_iter(3'd2, 32'hFFFFFF9C, 32'd7, "b2b_div2");
    run_iter(3'd3, 32'hFFFFFFFF, 32'd16, "b2b_divu");
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_vectors();
    test_mt();
    test_random();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
